// File: rtl/sliced_seq_adder_pkg.sv
// Shared definitions for the sliced sequential adder: FSM encoding and slice
// geometry helpers.
package sliced_seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nslice(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit chunk_fits(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/sliced_seq_adder_chunk_adder.sv
// CHUNK-bit ripple-carry slice built from full_adder cells; also exposes the
// carry into its MSB so the top can derive signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/sliced_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice is reused for NSLICE
// cycles, linked by a registered carry, behind valid/ready handshakes.
module sliced_seq_adder
    import sliced_seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);
    localparam int NSLICE = nslice(WIDTH, CHUNK);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (!chunk_fits(WIDTH, CHUNK)) begin : g_chunk_check
        $error("sliced_seq_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             ovf_q, ovf_d;

    int               lo;
    logic [CHUNK-1:0] slice_a, slice_b, slice_s;
    logic             slice_co, slice_cmsb;

    assign lo      = int'(idx_q) * CHUNK;
    assign slice_a = a_q[lo +: CHUNK];
    assign slice_b = b_q[lo +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (slice_a),
        .b     (slice_b),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_cmsb)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        result_d  = result_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Subtraction is A + ~B + 1; cin is deliberately dropped.
                    a_d      = a;
                    b_d      = sub ? ~b : b;
                    carry_d  = sub ? 1'b1 : cin;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[lo +: CHUNK] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    sum_d   = {slice_co, result_d};
                    ovf_d   = slice_cmsb ^ slice_co;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_sliced_seq_adder.sv
// Bench for sliced_seq_adder: four geometries (6/2, 6/3, 16/4, 8/8) checked
// against an arithmetic reference model.
module tb_sliced_seq_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  iv;
    logic [3:0]  ordy;
    logic [3:0]  cin_v;
    logic [3:0]  sub_v;
    logic [15:0] a_v [4];
    logic [15:0] b_v [4];
    wire  [3:0]  irdy;
    wire  [3:0]  ovld;
    wire  [3:0]  ovf;
    wire  [6:0]  s0;
    wire  [6:0]  s1;
    wire  [16:0] s2;
    wire  [8:0]  s3;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    sliced_seq_adder #(.WIDTH(6), .CHUNK(2)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a_v[0][5:0]), .b(b_v[0][5:0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(s0), .overflow(ovf[0]));

    sliced_seq_adder #(.WIDTH(6), .CHUNK(3)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a_v[1][5:0]), .b(b_v[1][5:0]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(s1), .overflow(ovf[1]));

    sliced_seq_adder #(.WIDTH(16), .CHUNK(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(s2), .overflow(ovf[2]));

    sliced_seq_adder #(.WIDTH(8), .CHUNK(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(irdy[3]),
        .a(a_v[3][7:0]), .b(b_v[3][7:0]), .cin(cin_v[3]), .sub(sub_v[3]),
        .out_valid(ovld[3]), .out_ready(ordy[3]), .sum(s3), .overflow(ovf[3]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [16:0] get_sum(input int k);
        case (k)
            0:       return {10'b0, s0};
            1:       return {10'b0, s1};
            2:       return s2;
            default: return {8'b0, s3};
        endcase
    endfunction

    function automatic int width_of(input int k);
        case (k)
            0, 1:    return 6;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    // Reference: unsigned result and carry/no-borrow from plain integers,
    // overflow from the signed interpretation leaving the representable range.
    function automatic logic [17:0] model(input int k, input logic [15:0] ai,
                                          input logic [15:0] bi, input logic ci,
                                          input logic si);
        int          w  = width_of(k);
        longint      m  = longint'(1) << w;
        longint      ua = longint'(ai) % m;
        longint      ub = longint'(bi) % m;
        longint      sa = (ua >= m / 2) ? ua - m : ua;
        longint      sb = (ub >= m / 2) ? ub - m : ub;
        longint      res, sr;
        logic        carry, ov;
        logic [16:0] s;
        if (si) begin
            res   = (ua - ub + m) % m;
            carry = (ua >= ub);
            sr    = sa - sb;
        end else begin
            res   = ua + ub + longint'(ci);
            carry = (res >= m);
            res   = res % m;
            sr    = sa + sb + longint'(ci);
        end
        ov   = (sr >= m / 2) || (sr < -(m / 2));
        s    = 17'(res);
        s[w] = carry;
        return {ov, s};
    endfunction

    task automatic issue(input int k, input logic [15:0] ai, input logic [15:0] bi,
                         input logic ci, input logic si, input bit hold_iv,
                         output bit ok);
        a_v[k]   = ai;
        b_v[k]   = bi;
        cin_v[k] = ci;
        sub_v[k] = si;
        iv[k]    = 1'b1;
        ok       = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (irdy[k]) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!hold_iv) iv[k] = 1'b0;
        a_v[k]   = 16'($urandom);
        b_v[k]   = 16'($urandom);
        cin_v[k] = 1'($urandom);
        sub_v[k] = 1'($urandom);
    endtask

    task automatic wait_valid(input int k, output int lat, output bit ok);
        lat = 0;
        while (!ovld[k] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = ovld[k];
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_chk++;
            if (irdy[k] !== 1'b1) begin
                n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, irdy[k]);
            end
            n_chk++;
            if (ovld[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, ovld[k]);
            end
            n_chk++;
            if (get_sum(k) !== 17'd0) begin
                n_fail++; $display("FAIL reset_sum[%0d]: got %h want 0", k, get_sum(k));
            end
            n_chk++;
            if (ovf[k] !== 1'b0) begin
                n_fail++; $display("FAIL reset_overflow[%0d]: got %b want 0", k, ovf[k]);
            end
        end
    endtask

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] s;
        logic        o;
        logic [3:0]  lat;
    } dir_t;

    task automatic test_directed();
        dir_t tbl [6];
        bit   ok;
        int   lat;
        tbl[0] = '{2'd0, 16'd63,   16'd63,   1'b0, 1'b0, 17'd126,        1'b0, 4'd3};
        tbl[1] = '{2'd0, 16'd5,    16'd3,    1'b0, 1'b1, 17'b1_000010,   1'b0, 4'd3};
        tbl[2] = '{2'd0, 16'd3,    16'd5,    1'b0, 1'b1, 17'b0_111110,   1'b0, 4'd3};
        tbl[3] = '{2'd0, 16'd5,    16'd3,    1'b1, 1'b1, 17'b1_000010,   1'b0, 4'd3};
        tbl[4] = '{2'd1, 16'd31,   16'd1,    1'b0, 1'b0, 17'd32,         1'b1, 4'd2};
        tbl[5] = '{2'd1, 16'h20,   16'h20,   1'b0, 1'b0, 17'b1_000000,   1'b1, 4'd2};
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(int'(tbl[i].k), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b0, ok);
            wait_valid(int'(tbl[i].k), lat, ok);
            n_chk++;
            if (!ok || lat != int'(tbl[i].lat)) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tbl[i].lat);
            end
            n_chk++;
            if (get_sum(int'(tbl[i].k)) !== tbl[i].s) begin
                n_fail++; $display("FAIL dir%0d_sum: got %h want %h", i, get_sum(int'(tbl[i].k)), tbl[i].s);
            end
            n_chk++;
            if (ovf[tbl[i].k] !== tbl[i].o) begin
                n_fail++; $display("FAIL dir%0d_overflow: got %b want %b", i, ovf[tbl[i].k], tbl[i].o);
            end
        end
    endtask

    task automatic test_stall();
        bit          ok;
        int          lat;
        logic [16:0] snap;
        logic [17:0] exp;
        ordy[2] = 1'b0;
        exp = model(2, 16'h8000, 16'h8000, 1'b0, 1'b0);
        issue(2, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, ok);
        iv[2] = 1'b1;
        a_v[2] = 16'h0001;
        lat = 0;
        while (!ovld[2] && lat < 64) begin
            n_chk++;
            if (irdy[2] !== 1'b0) begin
                n_fail++; $display("FAIL stall_run_in_ready: got %b want 0 at step %0d", irdy[2], lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        n_chk++;
        if (lat != 4) begin
            n_fail++; $display("FAIL stall_latency: got %0d want 4", lat);
        end
        snap = get_sum(2);
        n_chk++;
        if ({ovf[2], snap} !== exp) begin
            n_fail++; $display("FAIL stall_result: got %b/%h want %b/%h", ovf[2], snap, exp[17], exp[16:0]);
        end
        for (int c = 0; c < 5; c++) begin
            iv[2] = c[0];
            @(posedge clk); #1;
            n_chk++;
            if (ovld[2] !== 1'b1 || irdy[2] !== 1'b0 || get_sum(2) !== snap) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got valid=%b ready=%b sum=%h want valid=1 ready=0 sum=%h",
                         c, ovld[2], irdy[2], get_sum(2), snap);
            end
        end
        iv[2]   = 1'b0;
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (ovld[2] !== 1'b0 || irdy[2] !== 1'b1) begin
            n_fail++; $display("FAIL stall_retire: got valid=%b ready=%b want valid=0 ready=1", ovld[2], irdy[2]);
        end
        repeat (6) begin @(posedge clk); #1; end
        n_chk++;
        if (ovld[2] !== 1'b0 || irdy[2] !== 1'b1 || get_sum(2) !== snap) begin
            n_fail++;
            $display("FAIL stall_not_queued: got valid=%b ready=%b sum=%h want valid=0 ready=1 sum=%h",
                     ovld[2], irdy[2], get_sum(2), snap);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        ordy[2] = 1'b1;
        issue(2, 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b0, ok);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ovld[2] !== 1'b0 || irdy[2] !== 1'b1 || get_sum(2) !== 17'd0 || ovf[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got valid=%b ready=%b sum=%h ovf=%b want 0/1/0/0",
                     ovld[2], irdy[2], get_sum(2), ovf[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(2, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, ok);
        wait_valid(2, lat, ok);
        n_chk++;
        if (!ok || lat != 4) begin
            n_fail++; $display("FAIL post_reset_latency: got %0d want 4", lat);
        end
        n_chk++;
        if (get_sum(2) !== 17'h10001 || ovf[2] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_sum: got %h/%b want 10001/0", get_sum(2), ovf[2]);
        end
    endtask

    task automatic test_random_16();
        bit          ok;
        int          lat;
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [17:0] exp;
        ordy[2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            exp = model(2, ra, rb, rc, rs);
            issue(2, ra, rb, rc, rs, 1'b0, ok);
            wait_valid(2, lat, ok);
            n_chk++;
            if (!ok || {ovf[2], get_sum(2)} !== exp) begin
                n_fail++;
                $display("FAIL rand16_%0d a=%h b=%h cin=%b sub=%b: got %b/%h want %b/%h",
                         i, ra, rb, rc, rs, ovf[2], get_sum(2), exp[17], exp[16:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          lat, hs, prev_hs;
        logic [15:0] ra, rb;
        logic        rc, rs;
        logic [17:0] exp;
        ordy[3] = 1'b1;
        prev_hs = 0;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 255)); rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom);                rs = 1'($urandom);
            exp = model(3, ra, rb, rc, rs);
            issue(3, ra, rb, rc, rs, 1'b1, ok);
            hs = cyc;
            n_chk++;
            if (!ok) begin
                n_fail++; $display("FAIL b2b_%0d_accept: got no handshake want handshake", i);
            end
            if (i > 0) begin
                n_chk++;
                if (hs - prev_hs != 3) begin
                    n_fail++; $display("FAIL b2b_%0d_interval: got %0d want 3", i, hs - prev_hs);
                end
            end
            prev_hs = hs;
            wait_valid(3, lat, ok);
            n_chk++;
            if (!ok || lat != 1) begin
                n_fail++; $display("FAIL b2b_%0d_latency: got %0d want 1", i, lat);
            end
            n_chk++;
            if ({ovf[3], get_sum(3)} !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d a=%h b=%h cin=%b sub=%b: got %b/%h want %b/%h",
                         i, ra[7:0], rb[7:0], rc, rs, ovf[3], get_sum(3), exp[17], exp[16:0]);
            end
        end
        iv[3] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        cin_v = '0;
        sub_v = '0;
        for (int k = 0; k < 4; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_stall();
        test_reset_mid_run();
        test_random_16();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
